// File: rtl/countdown_sequencer.sv
// Command-side sequencer for the load/halve/decrement counter: runs one job
// (load, optional halvings, decrement to zero) and reports done/err.
module countdown_sequencer #(
    parameter int WIDTH   = 8,
    parameter int HW      = 2,
    parameter int TIMEOUT = 300
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] start_value,
    input  logic [HW-1:0]    start_halves,
    input  logic             abort,
    output logic [WIDTH-1:0] load_value,
    output logic             latch,
    output logic             div,
    output logic             dec,
    input  logic [WIDTH-1:0] count_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] dec_count
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] DEC_MAX    = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HALVE,
        DECR,
        FINISH
    } state_t;

    state_t          state;
    logic [HW-1:0]   halves_left;
    logic [TW-1:0]   timer;
    logic            accept;
    logic            count_zero;

    assign start_ready = (state == IDLE) && !abort;
    assign accept      = start_valid && start_ready;
    assign busy        = (state != IDLE);
    assign count_zero  = (count_in == '0);

    // dec must react to the counter's current value, so it is decoded from
    // state rather than registered; abort suppresses it in the same cycle.
    assign dec = (state == DECR) && !count_zero && !abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            latch       <= 1'b0;
            div         <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            load_value  <= '0;
            dec_count   <= '0;
            halves_left <= '0;
            timer       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        load_value  <= start_value;
                        halves_left <= start_halves;
                        dec_count   <= '0;
                        err         <= 1'b0;
                        latch       <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    latch <= 1'b0;
                    timer <= '0;
                    if (abort) begin
                        state <= IDLE;
                    end else if (halves_left != '0) begin
                        div   <= 1'b1;
                        state <= HALVE;
                    end else begin
                        state <= DECR;
                    end
                end
                HALVE: begin
                    if (abort) begin
                        div   <= 1'b0;
                        state <= IDLE;
                    end else if (halves_left == HW'(1)) begin
                        div         <= 1'b0;
                        halves_left <= '0;
                        state       <= DECR;
                    end else begin
                        halves_left <= halves_left - 1'b1;
                    end
                end
                DECR: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (count_zero) begin
                        done  <= 1'b1;
                        err   <= 1'b0;
                        state <= FINISH;
                    end else begin
                        if (dec_count != DEC_MAX) begin
                            dec_count <= dec_count + 1'b1;
                        end
                        // The timeout cycle still issues its dec: exactly TIMEOUT decs.
                        if (timer == TIMER_LAST) begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= FINISH;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: a behavioural counter closes the loop and
// per-job expectations come from the documented latency arithmetic.
module tb_countdown_sequencer;

    localparam int W  = 8;
    localparam int HW = 2;
    localparam int TO = 60;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_valid;
    logic          start_ready;
    logic [W-1:0]  start_value;
    logic [HW-1:0] start_halves;
    logic          abort;
    logic [W-1:0]  load_value;
    logic          latch;
    logic          div;
    logic          dec;
    logic [W-1:0]  count_in;
    logic          busy;
    logic          done;
    logic          err;
    logic [W-1:0]  dec_count;

    int tests = 0;
    int fails = 0;

    logic         stuck = 1'b0;
    logic [W-1:0] cnt = '0;

    always #5 clk = ~clk;

    countdown_sequencer #(.WIDTH(W), .HW(HW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .start_value(start_value), .start_halves(start_halves), .abort(abort),
        .load_value(load_value), .latch(latch), .div(div), .dec(dec),
        .count_in(count_in), .busy(busy), .done(done), .err(err), .dec_count(dec_count)
    );

    // Counter being driven; stuck mode models a counter that never moves.
    always @(posedge clk) begin
        if (latch)    cnt <= load_value;
        else if (div) cnt <= cnt >> 1;
        else if (dec) cnt <= cnt - 1'b1;
    end
    assign count_in = stuck ? W'(5) : cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs a whole job; n is the number of decs the counter needs (huge when stuck).
    task automatic run_job(input logic [W-1:0] v, input int h, input bit stk, input string tag);
        int n, decs, donek;
        bit e;
        logic [5:0] expv;
        n     = stk ? 100000 : int'(v >> h);
        e     = (n >= TO);
        decs  = e ? TO : n;
        donek = e ? (2 + h + TO) : (3 + h + n);
        stuck = stk;
        @(negedge clk);
        start_valid  = 1'b1;
        start_value  = v;
        start_halves = HW'(h);
        #1;
        check($sformatf("%s ready", tag), start_ready, 1);
        for (int k = 1; k <= donek + 1; k++) begin
            @(negedge clk);
            start_valid = (k <= donek) ? 1'($urandom_range(0, 1)) : 1'b0;
            start_value = W'($urandom);
            start_halves = HW'($urandom);
            #1;
            expv = {k == 1,
                    (k >= 2) && (k <= 1 + h),
                    (k >= 2 + h) && (k < 2 + h + decs),
                    k == donek,
                    (k >= donek) ? e : 1'b0,
                    k <= donek};
            check($sformatf("%s k=%0d {latch,div,dec,done,err,busy}", tag, k),
                  {latch, div, dec, done, err, busy}, expv);
        end
        check($sformatf("%s dec_count", tag), dec_count, decs);
        check($sformatf("%s load_value", tag), load_value, v);
        start_valid = 1'b0;
        stuck = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rv;
        int rh;
        reset = 1'b1; start_valid = 1'b0; start_value = '0; start_halves = '0; abort = 1'b0;
        @(negedge clk);
        start_valid = 1'b1; start_value = 8'hAA;
        @(negedge clk); #1;
        check("reset outputs", {latch, div, dec, done, err, busy, load_value, dec_count}, 0);
        check("reset ready", start_ready, 1);
        @(negedge clk);
        reset = 1'b0; start_valid = 1'b0;

        run_job(8'd10,  0, 1'b0, "t1_v10");
        run_job(8'd200, 2, 1'b0, "t2_v200h2");
        run_job(8'd0,   0, 1'b0, "t3_zero");
        run_job(8'd77,  0, 1'b1, "t4_stuck_timeout");
        run_job(8'd59,  0, 1'b0, "n_below_timeout");
        run_job(8'd60,  0, 1'b0, "n_at_timeout");
        run_job(8'd255, 3, 1'b0, "max_halves");
        run_job(8'd1,   3, 1'b0, "halved_to_zero");

        // Abort during DECR after four decs; start_valid held throughout.
        @(negedge clk);
        start_valid = 1'b1; start_value = 8'd20; start_halves = '0;
        #1;
        check("abort ready", start_ready, 1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start_value = 8'd99;
            #1;
            check($sformatf("abort k=%0d {latch,dec,busy}", k), {latch, dec, busy},
                  {k == 1, k >= 2, 1'b1});
        end
        @(negedge clk);
        abort = 1'b1;
        #1;
        check("abort cycle dec", dec, 0);
        check("abort cycle ready", start_ready, 0);
        @(negedge clk);
        abort = 1'b0; start_valid = 1'b0;
        #1;
        check("after abort {busy,dec,done,latch}", {busy, dec, done, latch}, 0);
        check("after abort ready", start_ready, 1);
        check("after abort dec_count", dec_count, 4);
        check("after abort load_value", load_value, 20);
        @(negedge clk); #1;
        check("no done after abort", {done, busy}, 0);

        // Abort in IDLE blocks the start and does nothing else.
        @(negedge clk);
        start_valid = 1'b1; abort = 1'b1; start_value = 8'd33;
        #1;
        check("idle abort ready", start_ready, 0);
        @(negedge clk);
        start_valid = 1'b0; abort = 1'b0;
        #1;
        check("idle abort {busy,latch}", {busy, latch}, 0);
        check("idle abort load_value", load_value, 20);

        // Reset while halving.
        @(negedge clk);
        start_valid = 1'b1; start_value = 8'd200; start_halves = 2'd3;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk); #1;
        check("pre-reset div", {div, busy}, 2'b11);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid-halve reset outputs",
              {latch, div, dec, done, err, busy, load_value, dec_count}, 0);
        run_job(8'd200, 2, 1'b0, "after_reset");

        for (int j = 0; j < 8; j++) begin
            rv = W'($urandom);
            rh = int'($urandom_range(0, 3));
            run_job(rv, rh, 1'b0, $sformatf("rand%0d_v%0d_h%0d", j, rv, rh));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
